// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: 2-flop synchroniser, tick divider,
// mid-bit sampling, false-start rejection, parity/framing flags.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = $clog2(DIV) + 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_param: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  state_t state, state_n;

  logic sync1, rxs, rxs_q;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic tick, sample, bitv, start_det, done, stop_last;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0] bcnt;
  logic stop_idx, perr_acc, ferr_acc;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      rxs_q <= rxs;
    end

  // Both counters restart on the start edge so sample points track the edge.
  assign tick = (tcnt == TW'(DIV - 1));

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (start_det) begin
      tcnt <= '0;
      scnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
      scnt <= (scnt == SW'(OVERSAMPLE - 1)) ? '0 : scnt + SW'(1);
    end else begin
      tcnt <= tcnt + TW'(1);
    end

`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP_IDX = OVERSAMPLE / 2;
  logic s0, s1;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else if (tick) begin
      if (scnt == SW'(SAMP_IDX - 2)) s0 <= rxs;
      if (scnt == SW'(SAMP_IDX - 1)) s1 <= rxs;
    end

  // Third vote is the live sample on the decision tick.
  assign bitv = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
`else
  localparam int SAMP_IDX = OVERSAMPLE / 2 - 1;
  assign bitv = rxs;
`endif

  assign sample    = tick && (scnt == SW'(SAMP_IDX));
  assign stop_last = (int'(stop_idx) == STOP_BITS - 1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else     state <= state_n;

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:
        if (rxs_q && !rxs) begin
          state_n   = S_START;
          start_det = 1'b1;
        end
      S_START:
        if (sample) state_n = bitv ? S_IDLE : S_DATA;
      S_DATA:
        if (sample && bcnt == BW'(DATA_BITS - 1))
          state_n = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:
        if (sample) state_n = S_STOP;
      S_STOP:
        if (sample && stop_last) begin
          state_n = S_IDLE;
          done    = 1'b1;
        end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg      <= '0;
      bcnt       <= '0;
      stop_idx   <= 1'b0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= done;
      if (start_det) begin
        bcnt     <= '0;
        stop_idx <= 1'b0;
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end
      if (sample) begin
        case (state)
          S_DATA: begin
            shreg <= {bitv, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + BW'(1);
          end
          S_PARITY: perr_acc <= ((^shreg) ^ bitv) != (PARITY == 1);
          S_STOP: begin
            ferr_acc <= ferr_acc | ~bitv;
            stop_idx <= stop_idx + 1'b1;
          end
          default: ;
        endcase
      end
      if (done) begin
        rx_data    <= shreg;
        parity_err <= (PARITY != 0) && perr_acc;
        frame_err  <= ferr_acc | ~bitv;
      end
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8N1 receiver in the telemetry path.
- Takes the asynchronous serial line from the board connector and delivers parallel words with a one-cycle valid strobe.
- Data width, parity mode, stop-bit count and oversampling ratio are configurable.
- Adds oversampled mid-bit sampling, false-start rejection, and parity/framing error flags.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit period; even, 8..32.
- DATA_BITS, 8, data bits per frame; 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- rx_in  input  1  serial line, idle high, LSB first; asynchronous to clk.
- rx_data  output  DATA_BITS  last received word.
- rx_valid  output  1  one-cycle strobe; rx_data and the error flags are valid.
- parity_err  output  1  parity mismatch on the frame in rx_data; forced 0 when PARITY=0.
- frame_err  output  1  at least one stop bit sampled low on the frame in rx_data.
- busy  output  1  high from start-bit detection until the frame completes or is rejected.

Behaviour:
- Reset (async, rst=1):
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchroniser flops=1; state=IDLE; all counters=0.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- Input synchroniser: two flops on rx_in. All logic below uses the synchronised value rxs.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division.
  - Elaboration error if DIV < 1.
  - Counter width $clog2(DIV)+1. Counts 0..DIV-1; tick is high for one clk when the counter wraps.
  - Counter free-runs in IDLE. It is cleared to 0 on start detection so sampling phase aligns to the edge.
- Sample counter (0..OVERSAMPLE-1) advances on tick. Bit sample point is tick count OVERSAMPLE/2-1 within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rxs falling edge (previous 1, current 0) -> START; busy=1.
  - START: at mid-bit sample:
    - rxs=1: false start -> IDLE, busy=0, no strobe.
    - rxs=0: -> DATA at the bit boundary.
  - DATA: one sample per bit, shifted in LSB first; bit counter 0..DATA_BITS-1. After the last bit -> PARITY if PARITY!=0, else -> STOP.
  - PARITY: sample the parity bit. Error if the XOR of data bits XOR parity bit does not match the mode:
    - even: total XOR must be 0;
    - odd: total XOR must be 1.
  - STOP: sample each of the STOP_BITS bits. Any low sample sets frame_err for this frame.
    - At the mid-sample of the final stop bit, register rx_data, parity_err and frame_err.
    - rx_valid=1 on the next clk, for exactly one cycle.
    - busy=0 on the same cycle; -> IDLE immediately, without waiting for the end of the stop bit.
- Latency: rx_valid asserts 1 clk after the final stop-bit sample tick, plus 2 clk of synchroniser delay relative to rx_in.
- Outputs rx_data, parity_err and frame_err hold until the next completed frame.
- Frame with all-zero data and frame_err=1 (break condition) is still delivered with rx_valid.
- After frame_err, IDLE requires a fresh 1->0 edge. A line held low does not retrigger.
- No handshake or backpressure: a consumer that misses rx_valid loses the word. There is no overrun flag.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit (start, data, parity, stop) is sampled at ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2.
  - The value is the 2-of-3 majority.
  - The decision and all state transitions occur at tick OVERSAMPLE/2.
  - rx_valid latency increases by 1 tick.
- Not defined: single sample at tick OVERSAMPLE/2-1; no majority logic is instantiated.

Test Plan:
- Bench config for all scenarios: CLK_FREQ=1536000, BAUD=9600, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
1. Defaults (8N1): send 0xA5 -> single rx_valid pulse; rx_data=0xA5, parity_err=0, frame_err=0; busy high ~1520 clk.
2. PARITY=2, DATA_BITS=7: send 0x55 with correct parity bit 0, then 0x55 with parity bit 1 -> parity_err=0, then parity_err=1; rx_data=0x55 both times.
3. STOP_BITS=2: send 0x3C with second stop bit driven low -> rx_valid with rx_data=0x3C, frame_err=1. Next clean frame 0x01 -> frame_err=0.
4. Glitch: drive rx_in low for 40 clk in IDLE -> busy pulses, no rx_valid, rx_data unchanged. A following 0x7E frame is received correctly.
5. Assert rst for 3 clk in the middle of data bit 4 of 0xFF -> all outputs 0 immediately and no rx_valid. Subsequent frame 0x12 is received correctly.
6. Two back-to-back frames 0x00 then 0xFF with a single stop bit and no idle gap -> two rx_valid pulses about 1600 clk apart, values 0x00 then 0xFF. With UART_RX_MAJORITY_EN, a 1-tick glitch at mid-bit does not corrupt either byte.
